// File: rtl/matriz_pkg.sv
// -----------------------------------------------------------------------------
// matriz_pkg
// Shared definitions for the packed-matrix datapath. Used by matriz_multi,
// matriz_result_reader and the matriz loader.
//   ELEM_W / STRIDE / MAX_N : layout of the packed 256-bit matrix word
//   SZ_2X2..SZ_5X5          : legal matrix size codes
//   state_e                 : result-reader FSM states
//   is_valid_size()         : size-code legality check
// -----------------------------------------------------------------------------
package matriz_pkg;

    localparam int ELEM_W = 8;
    localparam int STRIDE = 5;
    localparam int MAX_N  = 5;
    localparam int DATA_W = 256;

    localparam logic [2:0] SZ_2X2 = 3'd2;
    localparam logic [2:0] SZ_3X3 = 3'd3;
    localparam logic [2:0] SZ_4X4 = 3'd4;
    localparam logic [2:0] SZ_5X5 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_SUM  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic is_valid_size(input logic [2:0] sz);
        return (sz >= SZ_2X2) && (sz <= SZ_5X5);
    endfunction

endpackage

// File: rtl/matriz_result_reader_if.sv
// -----------------------------------------------------------------------------
// matriz_result_reader_if
// Element stream from the result reader toward the HPS/memory side.
//   elem_valid : beat valid          (master -> slave)
//   elem_ready : beat accepted       (slave  -> master)
//   elem_data  : element value       (master -> slave)
//   elem_row   : row index           (master -> slave)
//   elem_col   : column index        (master -> slave)
//   elem_last  : final beat          (master -> slave)
// -----------------------------------------------------------------------------
interface matriz_result_reader_if;
    import matriz_pkg::*;

    logic              elem_valid;
    logic              elem_ready;
    logic [ELEM_W-1:0] elem_data;
    logic [2:0]        elem_row;
    logic [2:0]        elem_col;
    logic              elem_last;

    modport master (
        output elem_valid, elem_data, elem_row, elem_col, elem_last,
        input  elem_ready
    );

    modport slave (
        input  elem_valid, elem_data, elem_row, elem_col, elem_last,
        output elem_ready
    );

endinterface

// File: rtl/matriz_elem_sel.sv
// -----------------------------------------------------------------------------
// matriz_elem_sel
// Combinational selector: picks element (row,col) out of the packed matrix,
// located at element index row*STRIDE+col. Indices beyond the packed word
// return zero.
//   data_i : packed matrix word
//   row_i  : row index
//   col_i  : column index
//   elem_o : selected element
// -----------------------------------------------------------------------------
module matriz_elem_sel
    import matriz_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int STRIDE = 5
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        row_i,
    input  logic [2:0]        col_i,
    output logic [ELEM_W-1:0] elem_o
);

    localparam int NUM_ELEM = DATA_W / ELEM_W;

    int idx;
    assign idx = int'(row_i) * STRIDE + int'(col_i);

    always_comb begin
        elem_o = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (k == idx) begin
                elem_o = data_i[k*ELEM_W +: ELEM_W];
            end
        end
    end

endmodule

// File: rtl/matriz_result_reader.sv
// -----------------------------------------------------------------------------
// matriz_result_reader
// Snapshots the packed result matrix on start and streams the active NxN
// elements row-major, one per valid/ready beat.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : capture-and-stream request (ignored unless IDLE)
//   size      : size code, 2..5 valid
//   data_c    : packed result matrix
//   elem      : element stream (master modport)
//   busy      : stream in progress
//   done      : one-cycle completion pulse
//   err       : one-cycle invalid-size pulse (with done)
// Optional feature macro: MATRIZ_RD_CHECKSUM_EN appends a mod-256 checksum
// beat (row=col=7) after the last element.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// SEND    | presenting element (row,col) of the snapshot
// SUM     | presenting checksum beat (macro builds only)
// FIN     | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module matriz_result_reader #(
    parameter int ELEM_W = matriz_pkg::ELEM_W,
    parameter int STRIDE = matriz_pkg::STRIDE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2:0]                    size,
    input  logic [255:0]                  data_c,
    matriz_result_reader_if.master        elem,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    import matriz_pkg::*;

    state_e            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [2:0]        n_q, n_d;
    logic [255:0]      snap_q, snap_d;
    logic              err_q, err_d;
`ifdef MATRIZ_RD_CHECKSUM_EN
    logic [ELEM_W-1:0] sum_q, sum_d;
`endif

    logic [ELEM_W-1:0] sel_data;
    logic [2:0]        last_idx;
    logic              hs;
    logic              valid_c, last_c;
    logic [ELEM_W-1:0] data_o_c;
    logic [2:0]        row_o_c, col_o_c;

    matriz_elem_sel #(
        .ELEM_W (ELEM_W),
        .STRIDE (STRIDE)
    ) u_sel (
        .data_i (snap_q),
        .row_i  (row_q),
        .col_i  (col_q),
        .elem_o (sel_data)
    );

    assign last_idx = n_q - 3'd1;
    // valid depends only on state, so ready never reaches valid/data combinationally
    assign hs       = valid_c && elem.elem_ready;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        n_d      = n_q;
        snap_d   = snap_q;
        err_d    = 1'b0;
`ifdef MATRIZ_RD_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        valid_c  = 1'b0;
        last_c   = 1'b0;
        data_o_c = sel_data;
        row_o_c  = row_q;
        col_o_c  = col_q;
        busy     = 1'b0;
        done     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_valid_size(size)) begin
                        snap_d  = data_c;
                        n_d     = size;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
`ifdef MATRIZ_RD_CHECKSUM_EN
                        sum_d   = '0;
`endif
                        state_d = ST_SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                valid_c = 1'b1;
                busy    = 1'b1;
`ifndef MATRIZ_RD_CHECKSUM_EN
                last_c  = (row_q == last_idx) && (col_q == last_idx);
`endif
                if (hs) begin
`ifdef MATRIZ_RD_CHECKSUM_EN
                    sum_d = sum_q + sel_data;
`endif
                    if (col_q == last_idx) begin
                        col_d = 3'd0;
                        if (row_q == last_idx) begin
                            row_d = 3'd0;
`ifdef MATRIZ_RD_CHECKSUM_EN
                            state_d = ST_SUM;
`else
                            state_d = ST_FIN;
`endif
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            ST_SUM: begin
`ifdef MATRIZ_RD_CHECKSUM_EN
                valid_c  = 1'b1;
                busy     = 1'b1;
                last_c   = 1'b1;
                data_o_c = sum_q;
                row_o_c  = 3'd7;
                col_o_c  = 3'd7;
                if (hs) begin
                    state_d = ST_FIN;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign elem.elem_valid = valid_c;
    assign elem.elem_last  = last_c;
    assign elem.elem_data  = data_o_c;
    assign elem.elem_row   = row_o_c;
    assign elem.elem_col   = col_o_c;
    assign err             = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            n_q     <= 3'd0;
            snap_q  <= '0;
            err_q   <= 1'b0;
`ifdef MATRIZ_RD_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            n_q     <= n_d;
            snap_q  <= snap_d;
            err_q   <= err_d;
`ifdef MATRIZ_RD_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: doc/matriz_result_reader.md
# matriz_result_reader

Sequential result reader for the matrix coprocessor. Snapshots the 256-bit packed result matrix `data_c` produced by `matriz_multi`, together with its `size` code, on a start strobe. It then streams the active N×N elements out one byte per beat, in row-major order, over a valid/ready handshake toward the HPS/memory side. It is the read-out end of the packed-matrix interface the multiplier writes.

## Interface
Parameters:
- ELEM_W, 8, element width in bits.
- STRIDE, 5, row stride in elements inside the packed 256-bit word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to capture and stream a result.
- size  in  3  matrix size code; 2..5 means N×N with N=size; 0,1,6,7 are invalid.
- data_c  in  256  packed result; element (r,c) at bits [ELEM_W*(r*STRIDE+c) +: ELEM_W].
- elem_valid  out  1  output beat valid.
- elem_ready  in  1  downstream accepts the beat.
- elem_data  out  8  element value.
- elem_row  out  3  row index of the beat.
- elem_col  out  3  column index of the beat.
- elem_last  out  1  final beat of the stream.
- busy  out  1  capture held, stream in progress.
- done  out  1  one-cycle pulse at stream completion.
- err  out  1  one-cycle pulse on invalid size.

## Operation
- Reset: all outputs 0, state IDLE, row/col counters 0, snapshot register cleared.
- States: IDLE, SEND, SUM (only with the macro below), FIN.
- IDLE + start with valid size:
  - latch data_c into the snapshot and N=size.
  - go to SEND with row=col=0 and busy=1.
  - later changes on data_c/size do not affect the stream.
- IDLE + start with invalid size: err=1 and done=1 for the next cycle; no beats are emitted; stay in IDLE.
- SEND:
  - elem_valid=1; elem_data/row/col reflect the current (row,col) from the snapshot.
  - Handshake occurs when elem_valid && elem_ready.
  - While elem_ready=0, all outputs hold stable.
- Index advance on handshake:
  - col++.
  - When col==N-1: col=0, row++.
  - On the handshake of (N-1,N-1): go to SUM if the macro is enabled, otherwise go to FIN.
- elem_last=1 only on the final beat of the stream.
- FIN: elem_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- start while busy or in FIN: ignored, with no effect on the stream.
- Asynchronous reset mid-stream: the stream is aborted immediately and all outputs return to reset values. done is not pulsed.
- Stride is always 5 regardless of N. Packed elements outside the N×N window are never emitted. Bits [255:200] are ignored.

## Timing
- start sampled at edge t; first beat valid in cycle t+1 (1-cycle latency).
- With elem_ready held at 1: one beat per cycle, N² beats (N²+1 with the macro).
- done is high in the cycle after the final handshake: cycle t+1+N² (plus 1 with the macro).
- Invalid size: err and done are both high in cycle t+1.
- Next start is accepted in the cycle after done. Minimum start-to-start interval is N²+2 cycles.
- No combinational path from elem_ready to elem_valid or elem_data.

## Configuration
- MATRIZ_RD_CHECKSUM_EN defined:
  - A running 8-bit sum modulo 256 of all emitted elements is accumulated.
  - After the last element, the SUM state emits one extra beat: elem_data=sum, elem_row=7, elem_col=7, elem_last=1.
  - In this mode, elem_last is 0 on element (N-1,N-1).
- Undefined: there is no SUM state and no accumulator. elem_last is on element (N-1,N-1).

## Structure
- Package matriz_pkg holds:
  - ELEM_W, STRIDE, MAX_N=5.
  - size code constants SZ_2X2..SZ_5X5.
  - the state enum.
  - an is_valid_size function.
- The package is shared with matriz_multi and the future matriz loader.
- One sub-module, matriz_elem_sel: a combinational 256→8 selector indexed by (row,col). The FSM, counters, snapshot and checksum stay in the top.

## Test plan
- 2×2, element (r,c)=0x10*r+c+1, elem_ready=1 -> beats 01,02,11,12 in consecutive cycles. last on 12, then done. No macro.
- Same stream with elem_ready low for 3 cycles on beat 2 -> beat 02 held stable; order and count unchanged.
- size=6 at start -> err and done pulse in the same cycle, zero beats, busy stays 0.
- 5×5, all elements 0xFF, MATRIZ_RD_CHECKSUM_EN -> 25 beats of FF, then beat data=0xE7 with row/col=7 and last=1.
- 3×3 with rst asserted after 4 beats -> valid/busy/done drop asynchronously; a new start then streams from (0,0).
- start pulsed mid-stream with data_c changed -> ignored; all beats match the original snapshot.
